muldiv_sequencer: RTL and testbench

- Multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage. Owns the HI/LO registers.
- Sequences a radix-2 shift-add multiply or a restoring divide over 32 iterations.
- Drives the EX-stage Stall whenever a HI/LO consumer or a new mul/div reaches EX while an operation is in flight.

---
 rtl/muldiv_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer with HI/LO ownership and EX stall generation.
// Optional build macro MULDIV_FAST_MULT_EN: single-cycle multiply in CALC (divide unchanged).
module muldiv_sequencer #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hilo_rd,
    input  logic [1:0]  hilo_we,
    input  logic        abort,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   acc_q, acc_d;
    logic [31:0]   dvsr_q, dvsr_d;
    logic [31:0]   rs_raw_q, rs_raw_d;
    logic          is_div_q, is_div_d;
    logic          neg_res_q, neg_res_d;
    logic          neg_rem_q, neg_rem_d;
    logic          div0_q, div0_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    // Operand conditioning: signed ops run on magnitudes, sign restored in FIXUP
    logic        signed_op;
    logic        rs_neg, rt_neg;
    logic [31:0] rs_abs, rt_abs;

    assign signed_op = ~op[0];
    assign rs_neg    = signed_op & rs_data[31];
    assign rt_neg    = signed_op & rt_data[31];
    assign rs_abs    = rs_neg ? (32'd0 - rs_data) : rs_data;
    assign rt_abs    = rt_neg ? (32'd0 - rt_data) : rt_data;

    // Shift-add multiply step: acc = {partial product, remaining multiplier bits}
    logic [32:0] mul_sum;
    logic [63:0] mul_step;

    assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, dvsr_q};
    assign mul_step = acc_q[0] ? {mul_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};

    // Restoring divide step: acc = {remainder, quotient}; shifted remainder is 33 bits wide
    logic        div_ge;
    logic [31:0] div_diff;
    logic [63:0] div_step;

    assign div_ge   = {1'b0, acc_q[63:31]} >= {2'b00, dvsr_q};
    assign div_diff = acc_q[62:31] - dvsr_q;
    assign div_step = div_ge ? {div_diff, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};

    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
    assign quot_fix = neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    assign rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

`ifdef MULDIV_FAST_MULT_EN
    logic [63:0] fast_prod;
    assign fast_prod = {32'd0, dvsr_q} * {32'd0, acc_q[31:0]};
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        dvsr_d    = dvsr_q;
        rs_raw_d  = rs_raw_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (abort) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = CALC;
                        count_d   = '0;
                        is_div_d  = op[1];
                        rs_raw_d  = rs_data;
                        neg_res_d = rs_neg ^ rt_neg;
                        neg_rem_d = rs_neg;
                        div0_d    = op[1] & (rt_data == 32'd0);
                        dvsr_d    = op[1] ? rt_abs : rs_abs;
                        acc_d     = op[1] ? {32'd0, rs_abs} : {32'd0, rt_abs};
                    end else begin
                        if (hilo_we[1]) hi_d = rs_data;
                        if (hilo_we[0]) lo_d = rs_data;
                    end
                end
                CALC: begin
                    acc_d   = is_div_q ? div_step : mul_step;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(ITER - 1)) begin
                        state_d = FIXUP;
                        count_d = '0;
                    end
`ifdef MULDIV_FAST_MULT_EN
                    if (!is_div_q) begin
                        acc_d   = fast_prod;
                        state_d = FIXUP;
                        count_d = '0;
                    end
`endif
                end
                FIXUP: begin
                    state_d = IDLE;
                    if (!is_div_q) begin
                        hi_d = prod_fix[63:32];
                        lo_d = prod_fix[31:0];
                    end else if (div0_q) begin
                        // Deterministic divide-by-zero result, no sign fixup
                        hi_d = rs_raw_q;
                        lo_d = 32'hFFFF_FFFF;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            dvsr_q    <= '0;
            rs_raw_q  <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            dvsr_q    <= dvsr_d;
            rs_raw_q  <= rs_raw_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == FIXUP) & ~abort;
    assign stall = busy & (start | hilo_rd | (hilo_we != 2'b00));
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer: arithmetic results, latency, stall, abort and reset.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, hilo_rd, abort;
    logic [1:0]  op, hilo_we;
    logic [31:0] rs_data, rt_data;
    logic        busy, stall, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int bcyc, dcnt, dseen;

`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_BUSY = 2;
`else
    localparam int MUL_BUSY = 33;
`endif
    localparam int DIV_BUSY = 33;

    muldiv_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .hilo_rd(hilo_rd),
        .hilo_we(hilo_we), .abort(abort), .busy(busy), .stall(stall),
        .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, then run until busy falls, counting busy cycles and done pulses
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int busy_cyc, output int done_cnt);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        tick();
        start = 1'b0; hilo_we = 2'b00;
        busy_cyc = 0; done_cnt = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            busy_cyc++;
            if (done) done_cnt++;
            tick();
        end
        check("busy_cleared", {31'd0, busy}, 32'd0);
        $display("op=%0d rs=0x%08h rt=0x%08h -> hi=0x%08h lo=0x%08h busy_cycles=%0d done_pulses=%0d",
                 o, a, b, hi, lo, busy_cyc, done_cnt);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
        hilo_rd = 1'b0; hilo_we = 2'b00; abort = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        // MTHI/MTLO while idle
        hilo_we = 2'b11; rs_data = 32'h0000_1234;
        #1 check("we_idle_stall", {31'd0, stall}, 32'd0);
        tick();
        hilo_we = 2'b00;
        check("we_hi", hi, 32'h0000_1234);
        check("we_lo", lo, 32'h0000_1234);
        $display("hilo_we=11 rs=0x1234 -> hi=0x%08h lo=0x%08h", hi, lo);

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bcyc, dcnt);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
        check("multu_busy_cycles", bcyc, MUL_BUSY);
        check("multu_done_once", dcnt, 32'd1);

        // Back-to-back: next op starts in the cycle after FIXUP
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, bcyc, dcnt);
        check("mult_neg_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", lo, 32'hFFFF_FFEB);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, bcyc, dcnt);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        check("div_busy_cycles", bcyc, DIV_BUSY);
        check("div_done_once", dcnt, 32'd1);

        do_op(2'b11, 32'd100, 32'd0, bcyc, dcnt);
        check("divu_zero_lo", lo, 32'hFFFF_FFFF);
        check("divu_zero_hi", hi, 32'd100);
        check("divu_zero_busy", bcyc, DIV_BUSY);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, bcyc, dcnt);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);

        // DIVU 1000/7 with a HI/LO consumer held in EX
        start = 1'b1; op = 2'b11; rs_data = 32'd1000; rt_data = 32'd7;
        tick();
        start = 1'b0; hilo_rd = 1'b1;
        bcyc = 0;
        for (int i = 0; i < 100 && busy; i++) begin
            bcyc++;
            #1 check("hilo_rd_stall", {31'd0, stall}, 32'd1);
            @(posedge clk); #1;
        end
        #1;
        check("hilo_rd_release", {31'd0, stall}, 32'd0);
        check("hilo_rd_cycles", bcyc, DIV_BUSY);
        check("divu_lo", lo, 32'd142);
        check("divu_hi", hi, 32'd6);
        $display("divu 1000/7 with hilo_rd -> stall cycles=%0d hi=0x%08h lo=0x%08h", bcyc, hi, lo);
        hilo_rd = 1'b0;

        // Abort at CALC count 10 keeps HI/LO and never pulses done
`ifdef MULDIV_FAST_MULT_EN
        start = 1'b1; op = 2'b11; rs_data = 32'd30; rt_data = 32'd5;
`else
        start = 1'b1; op = 2'b01; rs_data = 32'd5; rt_data = 32'd6;
`endif
        tick();
        start = 1'b0;
        dseen = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) dseen++;
            tick();
        end
        abort = 1'b1;
        #1 if (done) dseen++;
        tick();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (done) dseen++;
            tick();
        end
        check("abort_no_done", dseen, 32'd0);
        check("abort_hi", hi, 32'd6);
        check("abort_lo", lo, 32'd142);
        $display("abort at count 10 -> busy=%0d hi=0x%08h lo=0x%08h done_pulses=%0d", busy, hi, lo, dseen);

        // Same with reset mid-operation
        start = 1'b1; op = 2'b01; rs_data = 32'd5; rt_data = 32'd6;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        $display("rst at count 10 -> busy=%0d hi=0x%08h lo=0x%08h", busy, hi, lo);

        // start with hilo_we in the same idle cycle: write dropped
        hilo_we = 2'b11; start = 1'b1; op = 2'b01; rs_data = 32'd3; rt_data = 32'd4;
        #1 check("start_we_stall", {31'd0, stall}, 32'd0);
        do_op(2'b01, 32'd3, 32'd4, bcyc, dcnt);
        check("start_we_hi", hi, 32'd0);
        check("start_we_lo", lo, 32'd12);
        check("start_we_done", dcnt, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
